// File: rtl/dreimann_round_ctrl_if.sv
// Signal bundle between the dice controllers / button logic and the Dreimann round controller.
// master drives the dice inputs and the button; slave is the round controller.
interface dreimann_round_ctrl_if;
    logic [2:0] dice1;
    logic [2:0] dice2;
    logic       rolled1;
    logic       rolled2;
    logic       next_btn;
    logic [2:0] event_code;
    logic [1:0] drinks_dm;
    logic [2:0] player_id;
    logic [2:0] dm_id;
    logic       dm_valid;
    logic       eval_valid;
    logic       show_active;
    logic       clear_req;

    modport master (
        output dice1, dice2, rolled1, rolled2, next_btn,
        input  event_code, drinks_dm, player_id, dm_id, dm_valid,
               eval_valid, show_active, clear_req
    );

    modport slave (
        input  dice1, dice2, rolled1, rolled2, next_btn,
        output event_code, drinks_dm, player_id, dm_id, dm_valid,
               eval_valid, show_active, clear_req
    );
endinterface

// File: rtl/dreimann_round_ctrl.sv
// Dreimann game-rule stage: waits for both dice, classifies the throw, tracks player and
// Dreimann, holds the result until next_btn, then requests the dice controllers to re-arm.
module dreimann_round_ctrl #(
    parameter int NUM_PLAYERS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dreimann_round_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_EVAL  = 2'd1,
        S_SHOW  = 2'd2,
        S_CLEAR = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE   = 3'd0,
        EV_DREI   = 3'd1,
        EV_THREES = 3'd2,
        EV_PASCH  = 3'd3,
        EV_LEFT   = 3'd4,
        EV_RIGHT  = 3'd5,
        EV_NIX    = 3'd6,
        EV_ERR    = 3'd7
    } event_e;

    state_e     state_q, state_d;
    event_e     event_q, cls_event;
    logic [1:0] drinks_q, cls_drinks;
    logic [2:0] player_q, next_player;
    logic [2:0] dm_id_q;
    logic       dm_valid_q;
    logic       eval_valid_q;
    logic [3:0] dice_sum;
    logic [1:0] n_threes;
    logic       dice_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT:  if (bus.rolled1 && bus.rolled2) state_d = S_EVAL;
            S_EVAL:  state_d = S_SHOW;
            S_SHOW:  if (bus.next_btn) state_d = S_CLEAR;
            S_CLEAR: state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    // Throw classification, first matching rule wins.
    always_comb begin
        dice_sum   = {1'b0, bus.dice1} + {1'b0, bus.dice2};
        n_threes   = {1'b0, (bus.dice1 == 3'd3)} + {1'b0, (bus.dice2 == 3'd3)};
        dice_err   = (bus.dice1 == 3'd0) || (bus.dice1 == 3'd7) ||
                     (bus.dice2 == 3'd0) || (bus.dice2 == 3'd7);
        cls_event  = EV_NIX;
        cls_drinks = '0;
        if (dice_err) begin
            cls_event = EV_ERR;
        end else if (dice_sum == 4'd3) begin
            cls_event = EV_DREI;
        end else if (n_threes != 2'd0) begin
            cls_event  = EV_THREES;
            cls_drinks = dm_valid_q ? n_threes : '0;
        end else if (bus.dice1 == bus.dice2) begin
            cls_event = EV_PASCH;
        end else if (dice_sum == 4'd7) begin
            cls_event = EV_LEFT;
        end else if (dice_sum == 4'd8) begin
            cls_event = EV_RIGHT;
        end
    end

    assign next_player = (player_q == 3'(NUM_PLAYERS - 1)) ? '0 : player_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_q      <= EV_NONE;
            drinks_q     <= '0;
            player_q     <= '0;
            dm_id_q      <= '0;
            dm_valid_q   <= 1'b0;
            eval_valid_q <= 1'b0;
        end else begin
            eval_valid_q <= (state_q == S_EVAL);
            if (state_q == S_EVAL) begin
                event_q  <= cls_event;
                drinks_q <= cls_drinks;
                case (cls_event)
                    EV_DREI: begin
                        dm_id_q    <= player_q;
                        dm_valid_q <= 1'b1;
                    end
                    EV_NIX:  player_q <= next_player;
                    default: ;
                endcase
            end
        end
    end

    assign bus.event_code  = event_q;
    assign bus.drinks_dm   = drinks_q;
    assign bus.player_id   = player_q;
    assign bus.dm_id       = dm_id_q;
    assign bus.dm_valid    = dm_valid_q;
    assign bus.eval_valid  = eval_valid_q;
    assign bus.show_active = (state_q == S_SHOW);
    assign bus.clear_req   = (state_q == S_CLEAR);

endmodule
